// File: rtl/decap_bank_sequencer.sv
// rtl/decap_bank_sequencer.sv - staggered decap bank on/off sequencer; optional ramp abort via DECAP_SEQ_ABORT_EN
module decap_bank_sequencer #(
    parameter int NBANK = 8,
    parameter int DLY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [DLY_W-1:0] dly,
    output logic [NBANK-1:0] bank_en,
    output logic             ack,
    output logic             busy
);

    localparam int IDX_W = (NBANK > 2) ? $clog2(NBANK) : 1;
    localparam logic [IDX_W-1:0] TOP = IDX_W'(NBANK - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_RAMP_UP,
        S_ON,
        S_RAMP_DOWN
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx, idx_inc, idx_dec;
    logic [DLY_W-1:0] cnt, cnt_nx;
    logic [DLY_W-1:0] dly_q, dly_q_nx;
    logic [NBANK-1:0] bank_en_nx;
    logic             ack_nx;
    logic             abort_up;
    logic             abort_dn;

    // idx always names the bank most recently toggled by the active ramp
    assign idx_inc = idx + 1'b1;
    assign idx_dec = idx - 1'b1;

`ifdef DECAP_SEQ_ABORT_EN
    assign abort_up = ~req;
    assign abort_dn = req;
`else
    assign abort_up = 1'b0;
    assign abort_dn = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_OFF;
            idx     <= '0;
            cnt     <= '0;
            dly_q   <= '0;
            bank_en <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            dly_q   <= dly_q_nx;
            bank_en <= bank_en_nx;
            ack     <= ack_nx;
            busy    <= (state_nx == S_RAMP_UP) || (state_nx == S_RAMP_DOWN);
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        cnt_nx     = cnt;
        dly_q_nx   = dly_q;
        bank_en_nx = bank_en;
        ack_nx     = ack;
        case (state)
            S_OFF: begin
                if (req) begin
                    state_nx      = S_RAMP_UP;
                    bank_en_nx[0] = 1'b1;
                    idx_nx        = '0;
                    dly_q_nx      = dly;
                    cnt_nx        = dly;
                end
            end
            S_RAMP_UP: begin
                // Abort clears the just-enabled bank; the descent resumes below it
                if (abort_up) begin
                    state_nx        = S_RAMP_DOWN;
                    bank_en_nx[idx] = 1'b0;
                    cnt_nx          = dly_q;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (idx != TOP) begin
                    idx_nx              = idx_inc;
                    bank_en_nx[idx_inc] = 1'b1;
                    cnt_nx              = dly_q;
                end else begin
                    state_nx = S_ON;
                    ack_nx   = 1'b1;
                end
            end
            S_ON: begin
                if (!req) begin
                    state_nx          = S_RAMP_DOWN;
                    bank_en_nx[TOP]   = 1'b0;
                    idx_nx            = TOP;
                    dly_q_nx          = dly;
                    cnt_nx            = dly;
                end
            end
            S_RAMP_DOWN: begin
                // Re-enabling bank idx restores the level just above the current top
                if (abort_dn) begin
                    state_nx        = S_RAMP_UP;
                    bank_en_nx[idx] = 1'b1;
                    cnt_nx          = dly_q;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (idx != '0) begin
                    idx_nx              = idx_dec;
                    bank_en_nx[idx_dec] = 1'b0;
                    cnt_nx              = dly_q;
                end else begin
                    state_nx = S_OFF;
                    ack_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = S_OFF;
            end
        endcase
    end

endmodule
